// File: rtl/cpu2.sv
`default_nettype none
// ============================================================================
// Module   : cpu2
// Brief    : Accumulator CPU, 2 cycles/instruction, with a hex seven-segment display.
// Revision : 1.0
// ============================================================================
module cpu2 #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   run_i,
    input  logic                   prog_we_i,
    input  logic [WORD_W-OP_W-1:0] prog_addr_i,
    input  logic [WORD_W-1:0]      prog_data_i,
    output logic [WORD_W-1:0]      acc_o,
    output logic [WORD_W-OP_W-1:0] pc_o,
    output logic                   carry_o,
    output logic                   halted_o,
    output logic                   out_valid_o,
    output logic [6:0]             disp0_o,
    output logic [6:0]             disp1_o
);
    localparam int A_W   = WORD_W - OP_W;
    localparam int DEPTH = 2 ** A_W;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BZ    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OUT   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [A_W-1:0]      pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                carry_q, carry_d;
    logic [WORD_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [A_W-1:0]      mem_waddr;
    logic [WORD_W-1:0]   mem_wdata;

    logic [OP_W-1:0]     w_op;
    logic [A_W-1:0]      w_addr;
    logic [WORD_W-1:0]   w_operand;
    logic [WORD_W:0]     w_sum;
    logic [WORD_W:0]     w_diff;

    assign w_op      = ir_q[WORD_W-1:A_W];
    assign w_addr    = ir_q[A_W-1:0];
    assign w_operand = mem_q[w_addr];
    // The extra top bit of each result is the carry-out or borrow respectively.
    assign w_sum     = {1'b0, acc_q} + {1'b0, w_operand};
    assign w_diff    = {1'b0, acc_q} - {1'b0, w_operand};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr_i;
        mem_wdata   = prog_data_i;
        case (state_q)
            S_IDLE: begin
                pc_d   = '0;
                mem_we = prog_we_i;
                if (run_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                pc_d    = pc_q + A_W'(1);
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (w_op)
                    OP_LOAD:  acc_d = w_operand;
                    OP_STORE: begin
                        mem_we    = 1'b1;
                        mem_waddr = w_addr;
                        mem_wdata = acc_q;
                    end
                    OP_ADD: begin
                        acc_d   = w_sum[WORD_W-1:0];
                        carry_d = w_sum[WORD_W];
                    end
                    OP_SUB: begin
                        acc_d   = w_diff[WORD_W-1:0];
                        carry_d = w_diff[WORD_W];
                    end
                    OP_BZ: begin
                        if (acc_q == '0) begin
                            pc_d = w_addr;
                        end
                    end
                    OP_JMP:  pc_d = w_addr;
                    OP_OUT: begin
                        out_d       = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: ;
                endcase
            end
            S_HALTED: begin
                mem_we = prog_we_i;
                if (!run_i) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Memory has no reset; reset only suppresses the write so an aborted STORE is lost.
    always_ff @(posedge clock_i) begin
        if (!reset_i && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign acc_o       = acc_q;
    assign pc_o        = pc_q;
    assign carry_o     = carry_q;
    assign halted_o    = (state_q == S_HALTED);
    assign out_valid_o = out_valid_q;
    assign disp0_o     = seg7(out_q[3:0]);
    assign disp1_o     = seg7(out_q[7:4]);

endmodule
`default_nettype wire
